drive_cmd_arbiter: RTL and testbench
====================================

Name: drive_cmd_arbiter

Overview:
Parametrised N-source drive-command arbiter. It sits between the command producers (IR remote, pitch detector, vision direction, ultrasonic follow) and command_translator/uart_tx. Sources are ranked by fixed priority, and each source's ownership of the robot is held with a timeout. Repeated commands are suppressed, and an automatic stop is issued when the owner goes silent.

Parameters:
NUM_CH, 4, number of command sources; index 0 is the highest priority.
CMD_W, 3, drive command width.
HOLD_CYCLES, 12500000, clk cycles ownership persists after the owner's last request (250 ms at 50 MHz).
REPEAT_CYCLES, 25000000, minimum clk cycles before an identical command from the same channel is re-sent.
STOP_CMD, 0, command emitted when ownership times out.

Ports:
clk  in  1  system clock (clk_50 domain).
reset_n  in  1  synchronous, active-low reset.
src_valid  in  NUM_CH  one-cycle request strobe per channel.
src_cmd  in  NUM_CH*CMD_W  command per channel; channel i occupies [i*CMD_W +: CMD_W].
out_cmd  out  CMD_W  command to the translator.
out_valid  out  1  out_cmd is valid; held until accepted.
out_ready  in  1  translator can accept.
owner_valid  out  1  a channel currently owns the drive.
owner_ch  out  $clog2(NUM_CH)  owning channel index.
drop_count  out  16  discarded-request counter (see Optional Feature).

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - out_valid=0, out_cmd=STOP_CMD, owner_valid=0, owner_ch=0, drop_count=0.
  - All pending flags and timers are cleared.
  - Reset asserted mid-handshake drops out_valid on that edge, regardless of out_ready.
- Capture:
  - src_valid[i] sampled high sets pend[i] and latches pend_cmd[i].
  - A new strobe on a channel that is already pending overwrites its command.
- Eligibility: channel i is eligible if pend[i] and (owner_valid=0 or i<=owner_ch).
- Pending non-eligible channels are cleared in the same cycle and counted as drops.
- FSM states: IDLE, SEND, STOP.
  - IDLE, hold timer expired with owner_valid=1: clear owner_valid, out_cmd=STOP_CMD, out_valid=1, go to STOP. This takes precedence over pending requests in the same cycle.
  - IDLE, otherwise: select the lowest-index eligible channel k and clear pend[k].
    - Duplicate (k==owner_ch, owner_valid=1, pend_cmd[k]==last_cmd, repeat timer not expired): suppress it with no output, but reload the hold timer (keep-alive). This is not counted as a drop.
    - Not a duplicate: out_cmd=pend_cmd[k], out_valid=1, owner_ch=k, owner_valid=1, reload the hold timer to HOLD_CYCLES, go to SEND.
  - SEND or STOP: hold out_valid and out_cmd stable. On out_valid&&out_ready, clear out_valid, record last_cmd, reload the repeat timer to REPEAT_CYCLES, return to IDLE.
  - A higher-priority strobe arriving during SEND is captured but is not selected until the FSM returns to IDLE.
- Latency: src_valid high at edge t produces out_valid high after edge t+1 when the FSM is IDLE. With out_ready held high, one command transfers at most every 2 cycles.
- Hold timer:
  - Decrements every cycle while owner_valid=1 and saturates at 0.
  - The owner's own request (sent or suppressed) reloads it.
  - Preemption by a higher-priority channel transfers ownership and reloads the timer.
- Repeat timer: decrements to 0 and saturates there.
- Same-cycle events:
  - A strobe on channel k in the same cycle its pend is cleared by selection: the new command stays pending.
  - A strobe during the STOP-issue cycle: captured and evaluated against owner_valid=0 on the next IDLE cycle.
- Width rules:
  - Timer widths are $clog2(max(HOLD_CYCLES,REPEAT_CYCLES))+1.
  - NUM_CH=1 gives owner_ch width 1.

Optional Feature:
- Macro: DRIVE_CMD_ARB_STATS_EN.
- Defined: drop_count increments by the number of non-eligible pending channels cleared each cycle and saturates at 16'hFFFF.
- Undefined: no counter logic is built and drop_count is constant 0.

Test Plan:
Bench parameters: NUM_CH=4, CMD_W=3, HOLD_CYCLES=20, REPEAT_CYCLES=50, STOP_CMD=0.
- Basic transfer: reset, then pulse ch2 with cmd 5, out_ready=1 -> out_valid rises after the second edge with out_cmd=5; owner_ch=2, owner_valid=1.
- Backpressure: out_ready=0 for 10 cycles after ch1 sends cmd 3 -> out_cmd stays 3 and out_valid stays high; a single transfer occurs when out_ready=1.
- Preemption and drop: ch2 owns; pulse ch0 cmd 4 and ch3 cmd 6 in the same cycle -> output 4, owner_ch=0, ch3 dropped, drop_count=1 (0 without the macro).
- Duplicate suppression: ch1 sends cmd 2, then cmd 2 again 10 cycles later -> no second output; cmd 2 again after 50 cycles -> re-sent.
- Timeout: ch1 sends cmd 7, then silence -> 20 cycles after the transfer, out_cmd=0 with out_valid=1 and owner_valid=0; afterwards ch3 cmd 1 is accepted.
- Reset mid-operation: reset_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 and owner_valid=0 after that edge; no transfer occurs.

Source files
------------

// File: rtl/drive_cmd_arbiter.sv
// Fixed-priority N-source drive-command arbiter with ownership hold timeout, repeat suppression and auto-stop.
// Optional macro DRIVE_CMD_ARB_STATS_EN builds the saturating drop counter; otherwise drop_count is tied to 0.
module drive_cmd_arbiter #(
    parameter int NUM_CH        = 4,
    parameter int CMD_W         = 3,
    parameter int HOLD_CYCLES   = 12500000,
    parameter int REPEAT_CYCLES = 25000000,
    parameter int STOP_CMD      = 0
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic [NUM_CH-1:0]                             src_valid,
    input  logic [NUM_CH*CMD_W-1:0]                       src_cmd,
    output logic [CMD_W-1:0]                              out_cmd,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic                                          owner_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] owner_ch,
    output logic [15:0]                                   drop_count
);

    localparam int OWN_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;
    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES);
    localparam logic [TMR_W-1:0] REP_LD  = TMR_W'(REPEAT_CYCLES);
    localparam logic [CMD_W-1:0] STOP_V  = CMD_W'(STOP_CMD);

    typedef enum logic [1:0] {IDLE, SEND, STOP} state_t;

    state_t             state, state_n;
    logic [NUM_CH-1:0]  pend, pend_clr, elig, drop_mask;
    logic [CMD_W-1:0]   pend_cmd [NUM_CH];
    logic [CMD_W-1:0]   last_cmd, last_cmd_n, out_cmd_n, sel_cmd;
    logic [TMR_W-1:0]   hold_tmr, hold_n, rep_tmr, rep_n;
    logic [OWN_W-1:0]   sel, owner_ch_n;
    logic               sel_hit, is_dup, hold_done, rep_done;
    logic               out_valid_n, owner_valid_n;

    // Lower-priority pending requests than the current owner can never win, so they are discarded.
    always_comb begin
        elig      = '0;
        drop_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            elig[i]      = pend[i] && (!owner_valid || (OWN_W'(i) <= owner_ch));
            drop_mask[i] = pend[i] && !elig[i];
        end
    end

    always_comb begin
        sel     = '0;
        sel_hit = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel     = OWN_W'(i);
                sel_hit = 1'b1;
            end
        end
    end

    assign sel_cmd   = pend_cmd[sel];
    assign hold_done = (hold_tmr == '0);
    assign rep_done  = (rep_tmr == '0);
    assign is_dup    = owner_valid && (sel == owner_ch) && (sel_cmd == last_cmd) && !rep_done;

    // out_valid/out_cmd are held stable until a cycle with out_valid && out_ready completes the transfer.
    always_comb begin
        state_n       = state;
        out_cmd_n     = out_cmd;
        out_valid_n   = out_valid;
        owner_valid_n = owner_valid;
        owner_ch_n    = owner_ch;
        last_cmd_n    = last_cmd;
        pend_clr      = drop_mask;
        hold_n        = (owner_valid && !hold_done) ? hold_tmr - 1'b1 : hold_tmr;
        rep_n         = rep_done ? rep_tmr : rep_tmr - 1'b1;
        case (state)
            IDLE: begin
                if (owner_valid && hold_done) begin
                    owner_valid_n = 1'b0;
                    out_cmd_n     = STOP_V;
                    out_valid_n   = 1'b1;
                    state_n       = STOP;
                end else if (sel_hit) begin
                    pend_clr[sel] = 1'b1;
                    hold_n        = HOLD_LD;
                    if (!is_dup) begin
                        out_cmd_n     = sel_cmd;
                        out_valid_n   = 1'b1;
                        owner_ch_n    = sel;
                        owner_valid_n = 1'b1;
                        state_n       = SEND;
                    end
                end
            end
            SEND, STOP: begin
                if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    last_cmd_n  = out_cmd;
                    rep_n       = REP_LD;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            out_cmd     <= STOP_V;
            out_valid   <= 1'b0;
            owner_valid <= 1'b0;
            owner_ch    <= '0;
            last_cmd    <= STOP_V;
            hold_tmr    <= '0;
            rep_tmr     <= '0;
            pend        <= '0;
            for (int i = 0; i < NUM_CH; i++) pend_cmd[i] <= '0;
        end else begin
            state       <= state_n;
            out_cmd     <= out_cmd_n;
            out_valid   <= out_valid_n;
            owner_valid <= owner_valid_n;
            owner_ch    <= owner_ch_n;
            last_cmd    <= last_cmd_n;
            hold_tmr    <= hold_n;
            rep_tmr     <= rep_n;
            // A fresh strobe wins over a same-cycle clear so the new command is never lost.
            for (int i = 0; i < NUM_CH; i++) begin
                if (src_valid[i]) begin
                    pend[i]     <= 1'b1;
                    pend_cmd[i] <= src_cmd[i*CMD_W +: CMD_W];
                end else if (pend_clr[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

`ifdef DRIVE_CMD_ARB_STATS_EN
    logic [15:0] drop_num;
    logic [16:0] drop_sum;

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NUM_CH; i++) drop_num = drop_num + 16'(drop_mask[i]);
        drop_sum = {1'b0, drop_count} + {1'b0, drop_num};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) drop_count <= '0;
        else          drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Directed bench for drive_cmd_arbiter (NUM_CH=4, CMD_W=3, HOLD=20, REPEAT=50, STOP=0).
module tb_drive_cmd_arbiter;

`ifdef DRIVE_CMD_ARB_STATS_EN
    localparam int EXP_DROP = 1;
`else
    localparam int EXP_DROP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  src_valid = '0;
    logic [11:0] src_cmd = '0;
    logic [2:0]  out_cmd;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        owner_valid;
    logic [1:0]  owner_ch;
    logic [15:0] drop_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          xfer_cnt = 0;
    logic [2:0]  exp_q[$];

    drive_cmd_arbiter #(
        .NUM_CH(4), .CMD_W(3), .HOLD_CYCLES(20), .REPEAT_CYCLES(50), .STOP_CMD(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .src_valid(src_valid), .src_cmd(src_cmd),
        .out_cmd(out_cmd), .out_valid(out_valid), .out_ready(out_ready),
        .owner_valid(owner_valid), .owner_ch(owner_ch), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transfer happens at the posedge following a negedge where valid and ready are both high.
    always @(negedge clk) begin
        #1;
        if (reset_n && out_valid && out_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) check("xfer_extra", 32'(out_cmd), 32'hFF);
            else                   check("xfer_cmd", 32'(out_cmd), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [3:0] mask, input logic [11:0] cmds);
        src_valid = mask;
        src_cmd   = cmds;
        tick(1);
        src_valid = '0;
    endtask

    task automatic pulse(input int ch, input logic [2:0] cmd);
        logic [11:0] c;
        c = '0;
        c[ch*3 +: 3] = cmd;
        strobe(4'(1 << ch), c);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        exp_q.delete();
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        int base;
        logic hold_ok;

        // Reset state
        out_ready = 1'b1;
        tick(3);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_cmd", 32'(out_cmd), 0);
        check("rst_owner_valid", 32'(owner_valid), 0);
        check("rst_owner_ch", 32'(owner_ch), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        reset_n = 1'b1;
        tick(1);

        // Basic transfer with two-edge latency
        exp_q.push_back(3'd5);
        pulse(2, 3'd5);
        check("basic_latency", 32'(out_valid), 0);
        tick(1);
        check("basic_valid", 32'(out_valid), 1);
        check("basic_cmd", 32'(out_cmd), 5);
        check("basic_owner_ch", 32'(owner_ch), 2);
        check("basic_owner_valid", 32'(owner_valid), 1);
        tick(1);
        check("basic_valid_drop", 32'(out_valid), 0);
        check("basic_q_empty", 32'(exp_q.size()), 0);

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        base = xfer_cnt;
        exp_q.push_back(3'd3);
        pulse(1, 3'd3);
        tick(1);
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!(out_valid === 1'b1 && out_cmd === 3'd3)) hold_ok = 1'b0;
        end
        check("bp_held_stable", 32'(hold_ok), 1);
        check("bp_no_xfer", 32'(xfer_cnt - base), 0);
        out_ready = 1'b1;
        tick(1);
        check("bp_valid_drop", 32'(out_valid), 0);
        tick(3);
        check("bp_single_xfer", 32'(xfer_cnt - base), 1);

        // Preemption and drop
        do_reset();
        out_ready = 1'b1;
        exp_q.push_back(3'd1);
        pulse(2, 3'd1);
        tick(2);
        check("pre_owner_ch2", 32'(owner_ch), 2);
        exp_q.push_back(3'd4);
        strobe(4'b1001, {3'd6, 3'd0, 3'd0, 3'd4});
        tick(1);
        check("pre_valid", 32'(out_valid), 1);
        check("pre_cmd", 32'(out_cmd), 4);
        check("pre_owner_ch0", 32'(owner_ch), 0);
        check("pre_owner_valid", 32'(owner_valid), 1);
        check("pre_drop_count", 32'(drop_count), 32'(EXP_DROP));
        tick(3);
        check("pre_q_empty", 32'(exp_q.size()), 0);

        // Duplicate suppression and repeat expiry
        do_reset();
        check("dup_drop_cleared", 32'(drop_count), 0);
        out_ready = 1'b1;
        exp_q.push_back(3'd2);
        pulse(1, 3'd2);
        tick(2);
        base = xfer_cnt;
        for (int i = 0; i < 4; i++) begin
            tick(9);
            pulse(1, 3'd2);
        end
        tick(8);
        pulse(1, 3'd2);
        pulse(1, 3'd2);
        check("dup_suppressed", 32'(xfer_cnt - base), 0);
        check("dup_out_valid", 32'(out_valid), 0);
        check("dup_keepalive", 32'(owner_valid), 1);
        exp_q.push_back(3'd2);
        tick(1);
        check("dup_resend_valid", 32'(out_valid), 1);
        check("dup_resend_cmd", 32'(out_cmd), 2);
        tick(2);
        check("dup_resend_xfer", 32'(xfer_cnt - base), 1);

        // Ownership timeout and auto-stop
        do_reset();
        out_ready = 1'b1;
        exp_q.push_back(3'd7);
        pulse(1, 3'd7);
        tick(2);
        tick(19);
        check("to_before_valid", 32'(out_valid), 0);
        check("to_before_owner", 32'(owner_valid), 1);
        exp_q.push_back(3'd0);
        tick(1);
        check("to_stop_valid", 32'(out_valid), 1);
        check("to_stop_cmd", 32'(out_cmd), 0);
        check("to_owner_cleared", 32'(owner_valid), 0);
        tick(1);
        exp_q.push_back(3'd1);
        pulse(3, 3'd1);
        tick(1);
        check("to_new_valid", 32'(out_valid), 1);
        check("to_new_cmd", 32'(out_cmd), 1);
        check("to_new_owner_ch", 32'(owner_ch), 3);
        tick(2);
        check("to_q_empty", 32'(exp_q.size()), 0);

        // Reset in the middle of a stalled handshake
        do_reset();
        out_ready = 1'b0;
        pulse(2, 3'd6);
        tick(1);
        check("mid_valid_pre", 32'(out_valid), 1);
        base = xfer_cnt;
        reset_n = 1'b0;
        tick(1);
        check("mid_valid_rst", 32'(out_valid), 0);
        check("mid_owner_rst", 32'(owner_valid), 0);
        check("mid_cmd_rst", 32'(out_cmd), 0);
        out_ready = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("mid_no_xfer", 32'(xfer_cnt - base), 0);
        check("mid_idle_after", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
